// File: rtl/ysyx_23060236_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060236_mul_pkg
// Purpose  : Shared types and constants for the iterative multiplier.
//            - mul_state_e : controller states (IDLE/CALC/SIGN/DONE)
//            - MUL_UU/MUL_SU/MUL_SS : operand sign-mode encodings for mul_sign
//            - mul_cnt_width() : width of the step counter for XLEN/STEP
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060236_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    // mul_sign[1] marks mul1 signed, mul_sign[0] marks mul2 signed.
    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_SS = 2'b11;

    // The counter must be able to hold the full step count XLEN/STEP.
    function automatic int mul_cnt_width(input int xlen, input int step);
        return $clog2(xlen / step + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060236_mul_step.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060236_mul_step
// Purpose  : One combinational shift-add step of the iterative multiplier.
//            Retires the STEP low multiplier bits of res against mcand and
//            shifts the partial product down by STEP.
// Ports    : res      in  2*XLEN  current partial product / remaining multiplier
//            mcand    in  XLEN    multiplicand magnitude
//            res_next out 2*XLEN  value of res after this step
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060236_mul_step
    import ysyx_23060236_mul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic [2*XLEN-1:0] res,
    input  logic [XLEN-1:0]   mcand,
    output logic [2*XLEN-1:0] res_next
);

    // acc = res_hi + mcand * digit; XLEN+STEP bits always suffice since
    // (2^X-1) + (2^X-1)(2^S-1) = (2^X-1)*2^S < 2^(X+S).
    logic [XLEN+STEP-1:0] w_hi_ext;
    logic [XLEN+STEP-1:0] w_mcand_ext;
    logic [XLEN+STEP-1:0] w_digit_ext;
    logic [XLEN+STEP-1:0] w_prod;
    logic [XLEN+STEP-1:0] w_acc;

    assign w_hi_ext    = {{STEP{1'b0}}, res[2*XLEN-1:XLEN]};
    assign w_mcand_ext = {{STEP{1'b0}}, mcand};
    assign w_digit_ext = {{XLEN{1'b0}}, res[STEP-1:0]};
    assign w_prod      = w_mcand_ext * w_digit_ext;
    assign w_acc       = w_hi_ext + w_prod;

    generate
        if (STEP < XLEN) begin : g_shift
            assign res_next = {w_acc, res[XLEN-1:STEP]};
        end else begin : g_full
            // Whole multiplier consumed in one step; acc is the full product.
            assign res_next = w_acc;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ysyx_23060236_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060236_mul_iter
// Purpose  : Iterative XLEN x XLEN -> 2*XLEN multiplier retiring STEP
//            multiplier bits per cycle, with signed/unsigned operand modes,
//            output backpressure and flush. Latency XLEN/STEP+1 cycles.
// Ports    : clock, reset        clock, synchronous active-high reset
//            mul_valid/mul_ready request handshake (ready only in IDLE)
//            mul_sign[1:0]       bit1 mul1 signed, bit0 mul2 signed
//            mul1, mul2          multiplicand, multiplier
//            mul_flush           kills any in-flight or held operation
//            mul_outvalid/ready  result handshake, result held until taken
//            mul_high, mul_low   upper / lower halves of the product
// Config   : YSYX_23060236_MUL_ZERO_SKIP_EN - when defined, a zero operand
//            magnitude jumps straight to DONE with a zero product.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060236_mul_iter
    import ysyx_23060236_mul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mul_valid,
    output logic            mul_ready,
    input  logic [1:0]      mul_sign,
    input  logic [XLEN-1:0] mul1,
    input  logic [XLEN-1:0] mul2,
    input  logic            mul_flush,
    output logic            mul_outvalid,
    input  logic            mul_outready,
    output logic [XLEN-1:0] mul_high,
    output logic [XLEN-1:0] mul_low
);

    localparam int c_num_steps = XLEN / STEP;
    localparam int c_cnt_w     = mul_cnt_width(XLEN, STEP);
    localparam int c_res_w     = 2 * XLEN;
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(c_num_steps - 1);

    mul_state_e          r_state;
    logic                r_ready;
    logic                r_outvalid;
    logic                r_neg;
    logic [XLEN-1:0]     r_mcand;
    logic [c_res_w-1:0]  r_res;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_sign1;
    logic                w_sign2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic [c_res_w-1:0]  w_res_next;

    // Magnitudes are taken as unsigned XLEN, so the most negative value
    // negates to itself and is still the correct magnitude.
    assign w_sign1 = mul_sign[1] & mul1[XLEN-1];
    assign w_sign2 = mul_sign[0] & mul2[XLEN-1];
    assign w_mag1  = w_sign1 ? (~mul1 + XLEN'(1)) : mul1;
    assign w_mag2  = w_sign2 ? (~mul2 + XLEN'(1)) : mul2;

    ysyx_23060236_mul_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .res      (r_res),
        .mcand    (r_mcand),
        .res_next (w_res_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_outvalid <= 1'b0;
            r_neg      <= 1'b0;
            r_mcand    <= '0;
            r_res      <= '0;
            r_count    <= '0;
        end else if (mul_flush) begin
            // Flush outranks both a same-cycle accept and output handshake.
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_outvalid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mul_valid) begin
                        r_neg   <= w_sign1 ^ w_sign2;
                        r_mcand <= w_mag1;
                        r_res   <= {{XLEN{1'b0}}, w_mag2};
                        r_count <= '0;
                        r_ready <= 1'b0;
`ifdef YSYX_23060236_MUL_ZERO_SKIP_EN
                        if ((w_mag1 == '0) || (w_mag2 == '0)) begin
                            r_res      <= '0;
                            r_state    <= DONE;
                            r_outvalid <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
`else
                        r_state <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_res   <= w_res_next;
                    r_count <= r_count + c_cnt_w'(1);
                    if (r_count == c_last_step) begin
                        r_state <= SIGN;
                    end
                end
                SIGN: begin
                    r_res      <= r_neg ? (~r_res + c_res_w'(1)) : r_res;
                    r_state    <= DONE;
                    r_outvalid <= 1'b1;
                end
                DONE: begin
                    if (mul_outready) begin
                        r_state    <= IDLE;
                        r_outvalid <= 1'b0;
                        r_ready    <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_ready    <= 1'b1;
                    r_outvalid <= 1'b0;
                end
            endcase
        end
    end

    assign mul_ready    = r_ready;
    assign mul_outvalid = r_outvalid;
    assign mul_high     = r_res[c_res_w-1:XLEN];
    assign mul_low      = r_res[XLEN-1:0];

endmodule
`default_nettype wire
